// File: rtl/ssc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssc_seq_ctrl
// Purpose  : Multi-cycle sequencer for the snack-shopping calculator.
//            It accepts one purchase over a valid/ready handshake and checks
//            the 16-digit card number with the Luhn rule, one digit pair per
//            cycle. While it does that, it forms the eight item totals with
//            one shared multiplier. It then buys greedily, most expensive
//            item first, with one max-select and one subtractor per cycle.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid / in_ready - input handshake (ready only when idle)
//            card_num[63:0]      - 16 BCD digits, [63:60] leftmost
//            input_money[8:0]    - money inserted
//            snack_num[31:0]     - eight 4-bit quantities, item i = [4i+3:4i]
//            price[31:0]         - eight 4-bit unit prices, item i = [4i+3:4i]
//            out_valid           - one-cycle result strobe
//            out_ok              - card passed Luhn
//            out_change[8:0]     - remaining money
//            out_bought[7:0]     - bit i set if item i was purchased
// Revision : 1.0 - initial release
// ============================================================================
module ssc_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] card_num,
  input  logic [8:0]  input_money,
  input  logic [31:0] snack_num,
  input  logic [31:0] price,
  output logic        out_valid,
  output logic        out_ok,
  output logic [8:0]  out_change,
  output logic [7:0]  out_bought
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_DECIDE = 3'd2,
    S_BUY    = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [63:0] card_q, card_d;
  logic [31:0] snack_q, snack_d;
  logic [31:0] price_q, price_d;
  logic [8:0]  money_q, money_d;
  logic [7:0]  sum_q, sum_d;
  logic        bad_q, bad_d;
  logic [7:0]  considered_q, considered_d;
  logic [7:0]  bought_q, bought_d;
  logic [7:0]  total_q [8];
  logic [7:0]  total_d [8];
  logic        out_valid_q, out_valid_d;
  logic        out_ok_q, out_ok_d;
  logic [8:0]  out_change_q, out_change_d;
  logic [7:0]  out_bought_q, out_bought_d;

  // ---------------------------------------------------------------------------
  // Luhn digit slice. The card register is shifted left one byte per CHECK
  // step, so the current pair always sits in the top byte: [63:60] is the
  // doubled digit (nibble 15-2k) and [59:56] the plain digit (nibble 14-2k).
  // ---------------------------------------------------------------------------
  logic [3:0] dbl_nib;
  logic [3:0] pln_nib;
  logic [4:0] dbl_raw;
  logic [4:0] dbl_adj;
  logic [7:0] luhn_add;
  logic       nib_bad;

  assign dbl_nib  = card_q[63:60];
  assign pln_nib  = card_q[59:56];
  assign dbl_raw  = {dbl_nib, 1'b0};
  assign dbl_adj  = (dbl_raw > 5'd9) ? (dbl_raw - 5'd9) : dbl_raw;
  assign luhn_add = {3'b000, dbl_adj} + {4'b0000, pln_nib};
  assign nib_bad  = (dbl_nib > 4'd9) || (pln_nib > 4'd9);

  // ---------------------------------------------------------------------------
  // Shared multiplier. Quantity and price registers shift right one nibble per
  // CHECK step, so item k is always in the low nibble at step k.
  // ---------------------------------------------------------------------------
  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic [7:0] item_total;

  assign mul_a      = {4'b0000, snack_q[3:0]};
  assign mul_b      = {4'b0000, price_q[3:0]};
  assign item_total = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Shared max-select over unconsidered items. The strict '>' keeps the first
  // (lowest-index) item on a tie.
  // ---------------------------------------------------------------------------
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [7:0] sel_total;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    sel_total = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (!considered_q[i] && (!sel_found || (total_q[i] > sel_total))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_total = total_q[i];
      end
    end
  end

  logic card_pass;
  logic can_buy;

  assign card_pass = !bad_q && ((sum_q % 8'd10) == 8'd0);
  // Compare guards the subtraction, so money never underflows.
  assign can_buy   = sel_found && (sel_total != 8'd0) && (money_q >= {1'b0, sel_total});

  assign in_ready = (state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    card_d       = card_q;
    snack_d      = snack_q;
    price_d      = price_q;
    money_d      = money_q;
    sum_d        = sum_q;
    bad_d        = bad_q;
    considered_d = considered_q;
    bought_d     = bought_q;
    for (int i = 0; i < 8; i++) begin
      total_d[i] = total_q[i];
    end
    // Result registers are a one-cycle pulse; they fall back to zero unless
    // the state machine is entering OUT on this edge.
    out_valid_d  = 1'b0;
    out_ok_d     = 1'b0;
    out_change_d = 9'd0;
    out_bought_d = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          card_d       = card_num;
          snack_d      = snack_num;
          price_d      = price;
          money_d      = input_money;
          step_d       = 3'd0;
          sum_d        = 8'd0;
          bad_d        = 1'b0;
          considered_d = 8'd0;
          bought_d     = 8'd0;
          state_d      = S_CHECK;
        end
      end

      S_CHECK: begin
        sum_d           = sum_q + luhn_add;
        bad_d           = bad_q | nib_bad;
        total_d[step_q] = item_total;
        card_d          = {card_q[55:0], 8'd0};
        snack_d         = {4'd0, snack_q[31:4]};
        price_d         = {4'd0, price_q[31:4]};
        step_d          = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        step_d = 3'd0;
        if (card_pass) begin
          state_d = S_BUY;
        end else begin
          state_d      = S_OUT;
          out_valid_d  = 1'b1;
          out_ok_d     = 1'b0;
          out_change_d = money_q;
          out_bought_d = 8'd0;
        end
      end

      S_BUY: begin
        considered_d[sel_idx] = 1'b1;
        if (can_buy) begin
          money_d           = money_q - {1'b0, sel_total};
          bought_d[sel_idx] = 1'b1;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d      = S_OUT;
          out_valid_d  = 1'b1;
          out_ok_d     = 1'b1;
          out_change_d = money_d;
          out_bought_d = bought_d;
        end
      end

      S_OUT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= 3'd0;
      card_q       <= 64'd0;
      snack_q      <= 32'd0;
      price_q      <= 32'd0;
      money_q      <= 9'd0;
      sum_q        <= 8'd0;
      bad_q        <= 1'b0;
      considered_q <= 8'd0;
      bought_q     <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        total_q[i] <= 8'd0;
      end
      out_valid_q  <= 1'b0;
      out_ok_q     <= 1'b0;
      out_change_q <= 9'd0;
      out_bought_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      card_q       <= card_d;
      snack_q      <= snack_d;
      price_q      <= price_d;
      money_q      <= money_d;
      sum_q        <= sum_d;
      bad_q        <= bad_d;
      considered_q <= considered_d;
      bought_q     <= bought_d;
      for (int i = 0; i < 8; i++) begin
        total_q[i] <= total_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_ok_q     <= out_ok_d;
      out_change_q <= out_change_d;
      out_bought_q <= out_bought_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ok     = out_ok_q;
  assign out_change = out_change_q;
  assign out_bought = out_bought_q;

endmodule
`default_nettype wire

// File: tb/tb_ssc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssc_seq_ctrl
// Purpose  : Self-checking bench for ssc_seq_ctrl. Directed cases followed by
//            randomized transactions scored against a behavioural model of
//            the Luhn check and greedy purchase.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] card_num;
  logic [8:0]  input_money;
  logic [31:0] snack_num;
  logic [31:0] price;
  logic        out_valid;
  logic        out_ok;
  logic [8:0]  out_change;
  logic [7:0]  out_bought;

  int vectors;
  int miscompares;

  ssc_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .card_num    (card_num),
    .input_money (input_money),
    .snack_num   (snack_num),
    .price       (price),
    .out_valid   (out_valid),
    .out_ok      (out_ok),
    .out_change  (out_change),
    .out_bought  (out_bought)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Luhn rule over the 16 digits: rightmost digit is position 0, odd
  // positions are doubled (minus 9 if above 9); any non-decimal digit fails.
  function automatic bit luhn_ok(input logic [63:0] c);
    int  sum;
    int  d;
    bit  bad;
    sum = 0;
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      d = int'(c[4*j +: 4]);
      if (d > 9) bad = 1;
      if (j % 2 == 1) begin
        d = 2 * d;
        if (d > 9) d = d - 9;
      end
      sum = sum + d;
    end
    return !bad && (sum % 10 == 0);
  endfunction

  // Greedy purchase: visit items by descending total, lowest index first on
  // ties, buying any nonzero total that still fits.
  task automatic model(input logic [63:0] c, input logic [31:0] s, input logic [31:0] p,
                       input logic [8:0] m, output bit ok, output int ch,
                       output int bt, output int lat);
    int t [8];
    int order [8];
    int tmp;
    ok = luhn_ok(c);
    ch = int'(m);
    bt = 0;
    for (int i = 0; i < 8; i++) begin
      t[i]     = int'(s[4*i +: 4]) * int'(p[4*i +: 4]);
      order[i] = i;
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = a + 1; b < 8; b++) begin
        if (t[order[b]] > t[order[a]] ||
            (t[order[b]] == t[order[a]] && order[b] < order[a])) begin
          tmp      = order[a];
          order[a] = order[b];
          order[b] = tmp;
        end
      end
    end
    if (ok) begin
      for (int a = 0; a < 8; a++) begin
        if (t[order[a]] != 0 && t[order[a]] <= ch) begin
          ch = ch - t[order[a]];
          bt = bt | (1 << order[a]);
        end
      end
      lat = 17;
    end else begin
      lat = 9;
    end
  endtask

  // One transaction: present, accept, optionally keep in_valid asserted for
  // 'hold' edges, scramble the inputs, then wait for the result strobe.
  task automatic run_txn(input string name, input logic [63:0] c, input logic [31:0] s,
                         input logic [31:0] p, input logic [8:0] m, input int hold);
    bit ok_e;
    int ch_e;
    int bt_e;
    int lat_e;
    int n;
    model(c, s, p, m, ok_e, ch_e, bt_e, lat_e);
    @(negedge clk);
    check({name, "_ready_idle"}, in_ready, 1);
    card_num    = c;
    snack_num   = s;
    price       = p;
    input_money = m;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) in_valid = 1'b0;
    card_num    = {$urandom, $urandom};
    snack_num   = $urandom;
    price       = $urandom;
    input_money = 9'($urandom);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (k == hold) in_valid = 1'b0;
      if (k == 1) check({name, "_ready_busy"}, in_ready, 0);
      if (out_valid) break;
    end
    check({name, "_latency"}, n, lat_e);
    check({name, "_ok"}, out_ok, ok_e);
    check({name, "_change"}, out_change, ch_e);
    check({name, "_bought"}, out_bought, bt_e);
    @(posedge clk);
    #1;
    check({name, "_pulse_end"}, {out_valid, out_ok, out_change, out_bought}, 0);
    check({name, "_ready_after"}, in_ready, 1);
  endtask

  function automatic logic [63:0] make_valid_card();
    logic [63:0] c;
    for (int j = 1; j < 16; j++) c[4*j +: 4] = 4'($urandom_range(0, 9));
    c[3:0] = 4'd0;
    for (int d = 0; d < 10; d++) begin
      c[3:0] = 4'(d);
      if (luhn_ok(c)) break;
    end
    return c;
  endfunction

  logic [63:0] rc;
  int          highs;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    card_num    = 64'd0;
    snack_num   = 32'd0;
    price       = 32'd0;
    input_money = 9'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, out_ok, out_change, out_bought}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", in_ready, 1);

    // Directed cases
    run_txn("valid", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h8765_4321, 9'd20, 8);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    check("no_reaccept", highs, 0);
    run_txn("invalid", 64'h4111_1111_1111_1112, 32'h1111_1111, 32'h8765_4321, 9'd20, 0);
    run_txn("nonbcd", 64'hA000_0000_0000_0000, 32'h1111_1111, 32'h8765_4321, 9'd77, 0);
    run_txn("tie_zero", 64'h4111_1111_1111_1111, 32'h0000_0011, 32'h0000_0022, 9'd3, 0);
    run_txn("saturate", 64'h4111_1111_1111_1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'd511, 0);

    // Reset mid-BUY with in_valid held during CHECK
    @(negedge clk);
    card_num    = 64'h4111_1111_1111_1111;
    snack_num   = 32'h1111_1111;
    price       = 32'h8765_4321;
    input_money = 9'd20;
    in_valid    = 1'b1;
    @(posedge clk);
    highs = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (in_ready || out_valid) highs++;
    end
    check("busy_ignored", highs, 0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {out_valid, out_ok, out_change, out_bought}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", in_ready, 1);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    check("abort_no_strobe", highs, 0);
    run_txn("post_reset", 64'h4111_1111_1111_1111, 32'h1111_1111, 32'h8765_4321, 9'd20, 0);

    // Randomized transactions
    for (int r = 0; r < 24; r++) begin
      case (r % 3)
        0:       rc = make_valid_card();
        1:       rc = {$urandom, $urandom};
        default: begin
          rc = make_valid_card();
          rc[4*$urandom_range(1, 15) +: 4] = 4'($urandom_range(0, 9));
        end
      endcase
      run_txn("random", rc, $urandom, $urandom, 9'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
